maxpool2x2_stream: RTL and testbench

Parametrised 2×2 / stride-2 pooling engine for the CNN datapath, sitting between a convolution layer's output buffers and the next layer's input BRAMs. It accepts a raster-order pixel stream carrying all channels in parallel and pools each channel independently. A runtime mode input selects max or average pooling. It emits pooled pixels with a linear write address and a rotating bank select for the downstream BRAM set.

---
 rtl/maxpool2x2_stream.sv | 210 +++++++++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// 2x2 / stride-2 max or average pooling over a raster-order multi-channel
// pixel stream. Horizontal pairs of even rows are parked in a line buffer
// and merged with the matching pair of the following odd row; each pooled
// pixel is written out with a linear address and a rotating BRAM bank.
module maxpool2x2_stream #(
  parameter int BD    = 18,
  parameter int CH    = 3,
  parameter int W     = 64,
  parameter int H     = 64,
  parameter int NBANK = 4,
  parameter int AW    = (((W / 2) * (H / 2)) > 1) ? $clog2((W / 2) * (H / 2)) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [CH*BD-1:0]   in_data,
  output logic               busy,
  output logic               out_valid,
  output logic [CH*BD-1:0]   out_data,
  output logic [AW-1:0]      wraddr,
  output logic [1:0]         bram_num,
  output logic               done
);

  // Line-buffer index width; the column counter is one bit wider so that
  // its upper bits are directly the pair index.
  localparam int LW  = (W > 2) ? $clog2(W / 2) : 1;
  localparam int CW  = LW + 1;
  localparam int RW  = $clog2(H);
  localparam int PW  = BD + 1;
  localparam int LBD = 1 << LW;

  localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
  localparam logic [1:0]    BANK_LAST = 2'(NBANK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       col_r;
  logic [RW-1:0]       row_r;
  logic [AW-1:0]       addr_r;
  logic [1:0]          bank_r;
  logic                mode_r;
  logic                last_r;      // final pixel consumed, done pulse next
  logic [CH*BD-1:0]    hold_r;      // even-column pixel awaiting its partner
  logic [CH*PW-1:0]    lb_r [LBD];  // even-row pair results, one per column pair

  logic                take_s;
  logic [LW-1:0]       lb_idx_s;
  logic [CH*PW-1:0]    lb_rd_s;
  logic [CH*PW-1:0]    pair_s;
  logic [CH*BD-1:0]    quad_s;

  // Horizontal pair: max sign-extended to BD+1 bits, or the BD+1-bit sum.
  function automatic logic signed [PW-1:0] pair_fn(
    input logic signed [BD-1:0] a,
    input logic signed [BD-1:0] b,
    input logic                 avg
  );
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = {a[BD-1], a};
    be = {b[BD-1], b};
    if (avg) begin
      pair_fn = ae + be;
    end else if (ae > be) begin
      pair_fn = ae;
    end else begin
      pair_fn = be;
    end
  endfunction

  // Vertical merge of two pair results. The average divides the 4-pixel
  // sum by 4 with an arithmetic shift, i.e. floor toward minus infinity;
  // both the max and the floored mean always fit back into BD bits.
  function automatic logic [BD-1:0] quad_fn(
    input logic signed [PW-1:0] p,
    input logic signed [PW-1:0] q,
    input logic                 avg
  );
    logic signed [PW:0] s;
    s = {p[PW-1], p} + {q[PW-1], q};
    if (avg) begin
      quad_fn = BD'(s >>> 2'd2);
    end else if (p > q) begin
      quad_fn = BD'(p);
    end else begin
      quad_fn = BD'(q);
    end
  endfunction

  // A pixel is consumed only while running and before the frame is closed.
  always_comb begin
    take_s   = 1'b0;
    lb_idx_s = col_r[CW-1:1];
    lb_rd_s  = lb_r[lb_idx_s];
    if (state_r == ST_RUN && in_valid && !last_r) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  // Per-channel horizontal pair of the held pixel and the incoming one.
  always_comb begin
    pair_s = '0;
    for (int c = 0; c < CH; c++) begin
      pair_s[c*PW +: PW] = pair_fn(hold_r[c*BD +: BD], in_data[c*BD +: BD], mode_r);
    end
  end

  // Per-channel 2x2 result from the current pair and the buffered pair above.
  always_comb begin
    quad_s = '0;
    for (int c = 0; c < CH; c++) begin
      quad_s[c*BD +: BD] = quad_fn(pair_s[c*PW +: PW], lb_rd_s[c*PW +: PW], mode_r);
    end
  end

  // Line buffer write on the odd column of every even row.
  always_ff @(posedge clk) begin
    if (!reset && take_s && col_r[0] && !row_r[0]) begin
      lb_r[lb_idx_s] <= pair_s;
    end
  end

  // Frame FSM, raster counters and registered output port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      col_r     <= '0;
      row_r     <= '0;
      addr_r    <= '0;
      bank_r    <= 2'd0;
      mode_r    <= 1'b0;
      last_r    <= 1'b0;
      hold_r    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      wraddr    <= '0;
      bram_num  <= 2'd0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_RUN;
            col_r   <= '0;
            row_r   <= '0;
            addr_r  <= '0;
            bank_r  <= 2'd0;
            last_r  <= 1'b0;
            mode_r  <= mode;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (last_r) begin
            state_r <= ST_DONE;
            last_r  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (take_s) begin
            if (!col_r[0]) begin
              hold_r <= in_data;
            end
            if (col_r[0] && row_r[0]) begin
              out_valid <= 1'b1;
              out_data  <= quad_s;
              wraddr    <= addr_r;
              bram_num  <= bank_r;
              addr_r    <= addr_r + AW'(1);
              if (col_r == COL_LAST) begin
                bank_r <= (bank_r == BANK_LAST) ? 2'd0 : bank_r + 2'd1;
              end
            end
            if (col_r == COL_LAST) begin
              col_r <= '0;
              if (row_r == ROW_LAST) begin
                last_r <= 1'b1;
              end else begin
                row_r <= row_r + RW'(1);
              end
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream on a 4x10 frame (10 outputs, so the
// bank select wraps), with hand-derived expected pooled values.
module tb_maxpool2x2_stream;

  localparam int BD    = 18;
  localparam int CH    = 3;
  localparam int W     = 4;
  localparam int H     = 10;
  localparam int NBANK = 4;
  localparam int AW    = 4;
  localparam int NOUT  = (W / 2) * (H / 2);

  logic             clk;
  logic             reset;
  logic             start;
  logic             mode;
  logic             in_valid;
  logic [CH*BD-1:0] in_data;
  logic             busy;
  logic             out_valid;
  logic [CH*BD-1:0] out_data;
  logic [AW-1:0]    wraddr;
  logic [1:0]       bram_num;
  logic             done;

  int n_cmp;
  int n_err;

  logic [BD-1:0]    pix   [H][W][CH];
  logic [CH*BD-1:0] exp_o [NOUT];

  maxpool2x2_stream #(
    .BD(BD), .CH(CH), .W(W), .H(H), .NBANK(NBANK), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .wraddr(wraddr),
    .bram_num(bram_num), .done(done)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
    chk({tag, "_ov"},    {63'd0, out_valid}, 64'd0);
    chk({tag, "_data"},  64'(out_data), 64'd0);
    chk({tag, "_addr"},  64'(wraddr), 64'd0);
    chk({tag, "_bank"},  64'(bram_num), 64'd0);
    chk({tag, "_done"},  {63'd0, done}, 64'd0);
  endtask

  function automatic logic [CH*BD-1:0] pack(input int r, input int c);
    logic [CH*BD-1:0] v;
    v = '0;
    for (int ch = 0; ch < CH; ch++) v[ch*BD +: BD] = pix[r][c][ch];
    return v;
  endfunction

  // Ramp frame: channel ch pixel = 16*row + col + ch.
  // Max of a block = its bottom-right pixel = 32*br + 2*bk + 17 + ch.
  // Mean of a block = floor((4*base + 34)/4) = 32*br + 2*bk + ch + 8.
  task automatic fill_ramp(input logic avg);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int ch = 0; ch < CH; ch++)
          pix[r][c][ch] = BD'(16 * r + c + ch);
    for (int br = 0; br < H / 2; br++)
      for (int bk = 0; bk < W / 2; bk++)
        for (int ch = 0; ch < CH; ch++)
          exp_o[br * (W / 2) + bk][ch*BD +: BD] =
            avg ? BD'(32 * br + 2 * bk + ch + 8) : BD'(32 * br + 2 * bk + ch + 17);
  endtask

  // Drives one frame and checks every cycle's out_valid, and every pooled
  // output's data/address/bank, then the done pulse.
  task automatic run_frame(input string tag, input logic m, input int gap_pct,
                           input logic do_start, input logic busy_starts);
    int oi;
    int ngap;
    oi = 0;
    if (do_start) begin
      in_valid = 1'b0;
      start    = 1'b0;
      @(negedge clk);
      mode     = m;
      start    = 1'b1;
      in_valid = 1'b1;          // must be ignored in the start cycle
      in_data  = '1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      mode     = ~m;            // mode is latched, changes must not matter
      chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        ngap = ($urandom_range(0, 99) < gap_pct) ? $urandom_range(1, 3) : 0;
        for (int g = 0; g < ngap; g++) begin
          in_valid = 1'b0;
          in_data  = '1;
          start    = busy_starts;
          @(negedge clk);
          chk({tag, "_gap_ov"}, {63'd0, out_valid}, 64'd0);
        end
        in_valid = 1'b1;
        in_data  = pack(r, c);
        start    = busy_starts & c[0];
        @(negedge clk);
        if (r % 2 == 1 && c % 2 == 1) begin
          chk({tag, "_ov"},   {63'd0, out_valid}, 64'd1);
          chk({tag, "_data"}, 64'(out_data), 64'(exp_o[oi]));
          chk({tag, "_addr"}, 64'(wraddr), 64'(oi));
          chk({tag, "_bank"}, 64'(bram_num), 64'((oi / (W / 2)) % NBANK));
          chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
          oi++;
        end else begin
          chk({tag, "_ov_idle"}, {63'd0, out_valid}, 64'd0);
        end
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    chk({tag, "_done"},      {63'd0, done}, 64'd1);
    chk({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
    chk({tag, "_ov_end"},    {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("idle");

    // Max mode ramp, continuous input: ch0 = 17,19,49,51,...
    fill_ramp(1'b0);
    run_frame("max_ramp", 1'b0, 0, 1'b1, 1'b0);

    // Start during the done cycle is ignored; one cycle later it is taken.
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("start_in_done_busy", {63'd0, busy}, 64'd0);
    chk("start_in_done_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("start_after_done_busy", {63'd0, busy}, 64'd1);
    mode  = 1'b0;

    // Average mode with signed corner cases in block 0/1 ch0, block 2 ch1.
    fill_ramp(1'b1);
    pix[0][0][0] = 18'h3FFFF;  // -1
    pix[0][1][0] = 18'h3FFFE;  // -2
    pix[1][0][0] = 18'h3FFFE;  // -2
    pix[1][1][0] = 18'h3FFFE;  // -2
    exp_o[0][0 +: BD] = 18'h3FFFE;  // floor(-7/4) = -2
    for (int r = 0; r < 2; r++)
      for (int c = 2; c < 4; c++)
        pix[r][c][0] = 18'h1FFFF;  // 131071
    exp_o[1][0 +: BD] = 18'h1FFFF;
    for (int r = 2; r < 4; r++)
      for (int c = 0; c < 2; c++)
        pix[r][c][1] = 18'h20000;  // -131072
    exp_o[2][BD +: BD] = 18'h20000;
    run_frame("avg", 1'b1, 0, 1'b0, 1'b0);

    // Max mode with negatives, and random input gaps.
    fill_ramp(1'b0);
    pix[0][0][0] = 18'h3FFFB;  // -5
    pix[0][1][0] = 18'h3FFFD;  // -3
    pix[1][0][0] = 18'h20000;  // -131072
    pix[1][1][0] = 18'h3FFFC;  // -4
    exp_o[0][0 +: BD] = 18'h3FFFD;  // -3
    pix[0][2][0] = 18'h3FFFF;  // -1
    pix[0][3][0] = 18'h00000;  //  0
    pix[1][2][0] = 18'h3FFFE;  // -2
    pix[1][3][0] = 18'h3FFF9;  // -7
    exp_o[1][0 +: BD] = 18'h00000;
    run_frame("max_neg_gaps", 1'b0, 30, 1'b1, 1'b0);

    // Reset in the middle of a frame (row 6).
    @(negedge clk);
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 26; k++) begin
      in_valid = 1'b1;
      in_data  = pack(k / W, k % W);
      @(negedge clk);
    end
    chk("mid_frame_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_zero("mid_reset");
    reset = 1'b0;

    // Fresh frame after reset, with start pulses while busy.
    fill_ramp(1'b0);
    run_frame("post_reset", 1'b0, 0, 1'b1, 1'b1);
    @(negedge clk);
    chk("final_done_low", {63'd0, done}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
